// File: rtl/gs_wb_arbiter_if.sv
// gs_wb_arbiter_if: request and writeback bus of the writeback arbiter.
// Source i occupies slice i of req_rd / req_data (0 = ALU, 1 = load, 2 = mul/div).
// The slave modport is the arbiter; the master modport is its environment
// (the execute-stage producers plus the register-file port).
interface gs_wb_arbiter_if #(
   parameter int SRC_WIDTH = 32,
   parameter int RD_WIDTH  = 5
);
   logic [2:0]                 req_valid;
   logic [2:0]                 req_ready;
   logic [2:0][RD_WIDTH-1:0]   req_rd;
   logic [2:0][SRC_WIDTH-1:0]  req_data;
   logic                       wb_valid;
   logic                       wb_ready;
   logic [1:0]                 wb_sel;
   logic [RD_WIDTH-1:0]        wb_rd;
   logic [SRC_WIDTH-1:0]       wb_data;

   modport slave (
      input  req_valid, req_rd, req_data, wb_ready,
      output req_ready, wb_valid, wb_sel, wb_rd, wb_data
   );

   modport master (
      output req_valid, req_rd, req_data, wb_ready,
      input  req_ready, wb_valid, wb_sel, wb_rd, wb_data
   );
endinterface

// File: rtl/gs_wb_arbiter.sv
// gs_wb_arbiter: round-robin arbiter for the single register-file write port.
// Three writeback sources (0 = ALU, 1 = load, 2 = mul/div) compete each cycle;
// the winner is accepted whenever the single output register can load, and the
// winning select/destination/data appear on wb_* one cycle later.
// A winner with rd == 0 is accepted and consumes its turn but raises no write.
// Build option: define GS_WB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2
// (the rotating pointer is removed and tied to 0).

// Checker: structural invariants of the arbiter outputs.
module gs_wb_arbiter_chk (
   input logic       clk,
   input logic       rst,
   input logic [2:0] req_ready,
   input logic [1:0] wb_sel
);
   // At most one source is ever accepted in a cycle.
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   // The unused mux encoding is never selected.
   a_sel_legal: assert property (@(posedge clk) disable iff (rst) (wb_sel != 2'b11));
endmodule

module gs_wb_arbiter #(
   parameter int SRC_WIDTH = 32,
   parameter int RD_WIDTH  = 5
) (
   input logic            clk,
   input logic            rst,
   gs_wb_arbiter_if.slave bus
);

   // Rotating scan: first valid source starting at ptr, then ptr+1, ptr+2 (mod 3).
   function automatic logic [2:0] rr_pick(input logic [2:0] valid, input logic [1:0] ptr);
      logic [2:0] grant;
      grant = 3'b000;
      case (ptr)
         2'd1: begin
            if (valid[1])      grant = 3'b010;
            else if (valid[2]) grant = 3'b100;
            else if (valid[0]) grant = 3'b001;
            else               grant = 3'b000;
         end
         2'd2: begin
            if (valid[2])      grant = 3'b100;
            else if (valid[0]) grant = 3'b001;
            else if (valid[1]) grant = 3'b010;
            else               grant = 3'b000;
         end
         default: begin
            if (valid[0])      grant = 3'b001;
            else if (valid[1]) grant = 3'b010;
            else if (valid[2]) grant = 3'b100;
            else               grant = 3'b000;
         end
      endcase
      return grant;
   endfunction

   // One-hot grant to mux-select encoding (2'b00 / 2'b01 / 2'b10).
   function automatic logic [1:0] grant_index(input logic [2:0] grant);
      logic [1:0] idx;
      case (grant)
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Pointer after a transfer: the source following the winner gets top priority.
   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

   logic [1:0]           ptr_s;
   logic [2:0]           win_s;
   logic [1:0]           win_idx_s;
   logic                 load_s;
   logic [2:0]           req_ready_s;
   logic                 xfer_s;
   logic [RD_WIDTH-1:0]  win_rd_s;
   logic [SRC_WIDTH-1:0] win_data_s;

   logic                 wb_valid_r;
   logic [1:0]           wb_sel_r;
   logic [RD_WIDTH-1:0]  wb_rd_r;
   logic [SRC_WIDTH-1:0] wb_data_r;

`ifdef GS_WB_FIXED_PRIO_EN
   // Fixed priority: the scan always starts at source 0.
   assign ptr_s = 2'd0;
`else
   logic [1:0] ptr_r;

   // Priority pointer: moves past the winner on every accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= 2'd0;
      end else if (xfer_s) begin
         ptr_r <= next_ptr(win_idx_s);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr_s = ptr_r;
`endif

   // Same-cycle arbitration and acceptance; nothing is accepted while in reset.
   always_comb begin
      win_s       = rr_pick(bus.req_valid, ptr_s);
      win_idx_s   = grant_index(win_s);
      load_s      = !wb_valid_r || bus.wb_ready;
      req_ready_s = 3'b000;
      if (load_s && !rst) begin
         req_ready_s = win_s;
      end else begin
         req_ready_s = 3'b000;
      end
      xfer_s = |req_ready_s;
   end

   // Winner's destination and data, steered by the grant index.
   always_comb begin
      win_rd_s   = {RD_WIDTH{1'b0}};
      win_data_s = {SRC_WIDTH{1'b0}};
      case (win_idx_s)
         2'd1: begin
            win_rd_s   = bus.req_rd[1];
            win_data_s = bus.req_data[1];
         end
         2'd2: begin
            win_rd_s   = bus.req_rd[2];
            win_data_s = bus.req_data[2];
         end
         default: begin
            win_rd_s   = bus.req_rd[0];
            win_data_s = bus.req_data[0];
         end
      endcase
   end

   // Output register: load on transfer, drop valid on an idle load, hold on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_r <= 1'b0;
         wb_sel_r   <= 2'b00;
         wb_rd_r    <= {RD_WIDTH{1'b0}};
         wb_data_r  <= {SRC_WIDTH{1'b0}};
      end else if (xfer_s) begin
         wb_valid_r <= (win_rd_s != {RD_WIDTH{1'b0}});
         wb_sel_r   <= win_idx_s;
         wb_rd_r    <= win_rd_s;
         wb_data_r  <= win_data_s;
      end else if (load_s) begin
         wb_valid_r <= 1'b0;
      end else begin
         wb_valid_r <= wb_valid_r;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.wb_valid  = wb_valid_r;
   assign bus.wb_sel    = wb_sel_r;
   assign bus.wb_rd     = wb_rd_r;
   assign bus.wb_data   = wb_data_r;

   gs_wb_arbiter_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .req_ready (req_ready_s),
      .wb_sel    (wb_sel_r)
   );

endmodule

// File: doc/gs_wb_arbiter.md
# gs_wb_arbiter

Round-robin arbiter sharing the single register-file write port between three writeback sources: 0 = ALU, 1 = load unit, 2 = mul/div. It drives the select of the 3-input writeback mux using encodings 2'b00 / 2'b01 / 2'b10, and registers the winning destination and data. Valid/ready handshakes run on both sides. The block sits between execute-stage producers and the register file.

## Interface

**Parameters**
- `SRC_WIDTH`, 32, data width of each source and of `wb_data`.
- `RD_WIDTH`, 5, destination register index width.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  3  per-source request valid.
- `req_ready`  out  3  per-source accept; at most one bit high.
- `req_rd`  in  3×RD_WIDTH  per-source destination index (source i at slice i).
- `req_data`  in  3×SRC_WIDTH  per-source write data.
- `wb_valid`  out  1  registered write request to the register file.
- `wb_ready`  in  1  register-file port accepts this cycle.
- `wb_sel`  out  2  registered mux select of the current output: 2'b00 / 2'b01 / 2'b10.
- `wb_rd`  out  RD_WIDTH  registered destination index.
- `wb_data`  out  SRC_WIDTH  registered write data.

## Operation

**Output register.** A single output register stage exists. `load = !wb_valid || wb_ready`.

**Arbitration** (combinational, same cycle)
- The priority pointer `ptr` ∈ {0,1,2} names the highest-priority source.
- Scan order is ptr, ptr+1, ptr+2 (mod 3).
- The first source with `req_valid` set wins.

**Acceptance**
- `req_ready[i] = load && win[i]`.
- `req_ready` must not depend on `req_valid` of other sources in any way beyond the win computation.

**On transfer** (winner i accepted):
- `wb_sel <= i`, `wb_rd <= req_rd[i]`, `wb_data <= req_data[i]`, `ptr <= (i+1) mod 3`.
- `wb_valid <= (req_rd[i] != 0)`.

**x0 writes.** A winner with rd == 0 is accepted and consumes its turn, but produces no writeback (`wb_valid` = 0 next cycle).

**Idle load.** `load` high with no valid request gives `wb_valid <= 0`. `wb_sel`, `wb_rd`, `wb_data` and `ptr` hold.

**Stall.** `wb_valid && !wb_ready`:
- All outputs hold.
- `req_ready` = 0.
- `ptr` holds.

**Well-formedness.** Sources keep `req_valid`/`rd`/`data` stable until accepted; the block does not check this.

**Invalid select.** `wb_sel` = 2'b11 is never produced.

## Timing

**Reset** (asynchronous, immediate):
- `wb_valid` = 0, `wb_sel` = 2'b00, `wb_rd` = 0, `wb_data` = 0.
- `ptr` = 0; `req_ready` = 0 while `rst` is high.

**Latency.** A request accepted in cycle N appears on the `wb_*` outputs in cycle N+1.

**Throughput.** One write per cycle when `wb_ready` stays high (back-to-back transfers allowed, since `load` is true when `wb_ready` is high).

**Simultaneous requests.** All three valid with `ptr` = 0 gives grant order 0, 1, 2 over three consecutive cycles.

**Reset mid-stall.** Asserting `rst` while `wb_valid` = 1 drops the pending write; no partial state survives.

**Reset release.** The first grant is possible in the first cycle with `rst` low.

## Configuration

**`GS_WB_FIXED_PRIO_EN`**
- Defined: fixed priority 0 > 1 > 2; `ptr` is removed (tied to 0) and never updates.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan

1. **Reset.** Assert `rst` with all requests valid.
   - Required: all `wb_*` outputs 0, `req_ready` = 3'b000.
   - After release: `req_ready` = 3'b001.
2. **Round-robin.** `req_valid` = 3'b111 held, `wb_ready` = 1, rd = 1/2/3.
   - Required: `wb_sel` sequence 00, 01, 10, 00, with `wb_rd` 1, 2, 3, 1 starting the cycle after the first grant.
3. **Stall.** Source 1 accepted (rd = 7, data = 32'hDEADBEEF), then `wb_ready` = 0 for 3 cycles.
   - Required: outputs hold 01/7/DEADBEEF and `req_ready` = 0 throughout.
   - Next grant occurs in the same cycle `wb_ready` returns to 1.
4. **x0 write.** Source 2 alone with rd = 0.
   - Required: `req_ready[2]` = 1, next-cycle `wb_valid` = 0, `ptr` advances to 0.
5. **Fixed priority** (`GS_WB_FIXED_PRIO_EN` defined). `req_valid` = 3'b111 held.
   - Required: source 0 granted every cycle; sources 1 and 2 never granted.
6. **Async reset mid-stall.** Pulse `rst` between clock edges while `wb_valid` = 1.
   - Required: `wb_valid` falls to 0 without waiting for a clock edge.
